// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: synchronises and debounces scanner keys, shifts digits into a
// 4-digit entry register, and scans them onto a 4-anode seven-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros above the rightmost digit).
module keypad_entry_buffer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_CYCLES  = 100000,
    parameter bit CMD_KEYS        = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_val,
    input  logic        key_valid,
    output logic        press_pulse,
    output logic [15:0] digits,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RF_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RF_W-1:0] RF_MAX = RF_W'(REFRESH_CYCLES - 1);

    localparam logic [3:0] KEY_CLEAR     = 4'hF;
    localparam logic [3:0] KEY_BACKSPACE = 4'hE;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser and debounce counter
    // ------------------------------------------------------------------
    logic            valid_s1, valid_s2;
    logic [3:0]      val_s1, val_s2;
    logic [4:0]      prev_key;
    logic [DB_W-1:0] db_cnt;
    logic            key_changed;
    logic            db_stable;

    assign key_changed = ({valid_s2, val_s2} != prev_key);
    assign db_stable   = (db_cnt == DB_MAX);

    // NOTE: every clocked process uses non-blocking (<=) assignments so all
    // registers sample the pre-edge values of each other, exactly like hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            val_s1   <= 4'h0;
            val_s2   <= 4'h0;
            prev_key <= 5'h00;
            db_cnt   <= '0;
        end else begin
            valid_s1 <= key_valid;
            valid_s2 <= valid_s1;
            val_s1   <= key_val;
            val_s2   <= val_s1;
            prev_key <= {valid_s2, val_s2};
            if (key_changed) begin
                db_cnt <= '0;
            end else if (!db_stable) begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Press/release FSM
    // ------------------------------------------------------------------
    state_t state, state_nxt;
    logic   press_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaults are assigned before the case so no path leaves an output
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt    = state;
        press_accept = 1'b0;
        case (state)
            IDLE: begin
                if (valid_s2) begin
                    state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!valid_s2) begin
                    state_nxt = IDLE;
                end else if (db_stable) begin
                    state_nxt    = HELD;
                    press_accept = 1'b1;
                end
            end
            HELD: begin
                // Code changes while held are deliberately ignored.
                if (!valid_s2) begin
                    state_nxt = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (valid_s2) begin
                    state_nxt = HELD;
                end else if (db_stable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Entry register
    // ------------------------------------------------------------------
    logic [15:0] digits_nxt;

    always_comb begin
        digits_nxt = digits;
        if (press_accept) begin
            if (CMD_KEYS && (val_s2 == KEY_CLEAR)) begin
                digits_nxt = 16'h0000;
            end else if (CMD_KEYS && (val_s2 == KEY_BACKSPACE)) begin
                digits_nxt = {4'h0, digits[15:4]};
            end else begin
                digits_nxt = {digits[11:0], val_s2};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= 16'h0000;
            press_pulse <= 1'b0;
        end else begin
            digits      <= digits_nxt;
            press_pulse <= press_accept;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [RF_W-1:0] rf_cnt;
    logic [1:0]      scan_idx;
    logic [1:0]      idx_nxt;
    logic            scan_wrap;
    logic [3:0]      cur_digit;
    logic            blank;

    assign scan_wrap = (rf_cnt == RF_MAX);
    assign idx_nxt   = scan_wrap ? (scan_idx + 2'd1) : scan_idx;

    always_comb begin
        cur_digit = digits[3:0];
        case (idx_nxt)
            2'd1:    cur_digit = digits[7:4];
            2'd2:    cur_digit = digits[11:8];
            2'd3:    cur_digit = digits[15:12];
            default: cur_digit = digits[3:0];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank a position when it and every digit above it are zero; index 0 always shows.
    always_comb begin
        blank = 1'b0;
        case (idx_nxt)
            2'd1:    blank = (digits[15:4] == 12'h000);
            2'd2:    blank = (digits[15:8] == 8'h00);
            2'd3:    blank = (digits[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // an and seg are both derived from idx_nxt so they switch on the same edge as the index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_cnt   <= '0;
            scan_idx <= 2'd0;
            an       <= 4'b1110;
            seg      <= 7'b1000000;
        end else begin
            rf_cnt   <= scan_wrap ? '0 : (rf_cnt + RF_W'(1));
            scan_idx <= idx_nxt;
            an       <= ~(4'b0001 << idx_nxt);
            seg      <= blank ? 7'b1111111 : hex_to_seg(cur_digit);
        end
    end

endmodule
